// File: rtl/seg_scan_arbiter_if.sv
// Signal bundle between the two display clients and the scan arbiter.
// Request handshake: msg_req is sampled every cycle; it is accepted only when msg_ack pulses one cycle later.
interface seg_scan_arbiter_if;
    logic        disp_en;
    logic [15:0] a_code;
    logic [3:0]  a_blink;
    logic        msg_req;
    logic [15:0] msg_code;
    logic        msg_ack;
    logic        msg_busy;
    logic        owner;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;

    modport master (
        output disp_en, a_code, a_blink, msg_req, msg_code,
        input  msg_ack, msg_busy, owner, DIGIT, DISPLAY
    );

    modport slave (
        input  disp_en, a_code, a_blink, msg_req, msg_code,
        output msg_ack, msg_busy, owner, DIGIT, DISPLAY
    );
endinterface

// File: rtl/seg_scan_arbiter.sv
// 4-digit 7-segment scan controller; a transient message (B) preempts the live value (A)
// for whole frames only, using clock-enable counters for scan and blink timing.
module seg_scan_arbiter #(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int HOLD_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_arbiter_if.slave bus,
    output logic [1:0]        state_o
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_SHOW = 2'd2} state_t;

    logic [SW-1:0] sc_q;
    logic [1:0]    idx_q;
    logic [BW-1:0] bl_q;
    logic          phase_q;
    state_t        state_q, state_d;
    logic [FW-1:0] frames_q, frames_d;
    logic [15:0]   msg_q, msg_d;
    logic          ack_q, ack_d;
    logic [3:0]    digit_q, digit_d;
    logic [6:0]    display_q, display_d;
    logic          owner, busy;

    logic scan_tick, frame_bd, blink_tc;
    assign scan_tick = (sc_q == SC_LAST);
    assign frame_bd  = scan_tick && (idx_q == 2'd3);
    assign blink_tc  = (bl_q == BL_LAST);

    function automatic logic [6:0] glyph_seg(input logic [3:0] c);
        case (c)
            4'd0:    glyph_seg = 7'b100_0000;
            4'd1:    glyph_seg = 7'b111_1001;
            4'd2:    glyph_seg = 7'b010_0100;
            4'd3:    glyph_seg = 7'b011_0000;
            4'd4:    glyph_seg = 7'b001_1001;
            4'd5:    glyph_seg = 7'b001_0010;
            4'd6:    glyph_seg = 7'b000_0010;
            4'd7:    glyph_seg = 7'b111_1000;
            4'd8:    glyph_seg = 7'b000_0000;
            4'd9:    glyph_seg = 7'b001_0000;
            4'd10:   glyph_seg = 7'b101_1100;
            4'd11:   glyph_seg = 7'b110_0011;
            4'd12:   glyph_seg = 7'b000_1110;
            4'd13:   glyph_seg = 7'b001_0010;
            default: glyph_seg = 7'b111_1111;
        endcase
    endfunction

    // Scan and blink timebases keep running regardless of disp_en or ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q    <= '0;
            idx_q   <= 2'd0;
            bl_q    <= '0;
            phase_q <= 1'b1;
        end else begin
            sc_q <= scan_tick ? '0 : sc_q + 1'b1;
            if (scan_tick) idx_q <= idx_q + 2'd1;
            bl_q <= blink_tc ? '0 : bl_q + 1'b1;
            if (blink_tc) phase_q <= ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            frames_q <= '0;
            msg_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            msg_q    <= msg_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        msg_d    = msg_q;
        ack_d    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.msg_req) begin
                state_d = S_PEND;
                msg_d   = bus.msg_code;
                ack_d   = 1'b1;
            end
            S_PEND: if (frame_bd) begin
                state_d  = S_SHOW;
                frames_d = '0;
            end
            S_SHOW: if (frame_bd) begin
                if (frames_q == FR_LAST) state_d = S_IDLE;
                else                     frames_d = frames_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        owner   = (state_q == S_SHOW);
        busy    = (state_q != S_IDLE);
        state_o = state_q;
    end

    // Blink masking applies to the live value only; a message is never blanked.
    always_comb begin
        logic [3:0] glyph;
        glyph     = owner ? msg_q[{idx_q, 2'b00} +: 4] : bus.a_code[{idx_q, 2'b00} +: 4];
        display_d = (!owner && !phase_q && bus.a_blink[idx_q]) ? 7'b111_1111 : glyph_seg(glyph);
        digit_d   = bus.disp_en ? ~(4'b0001 << idx_q) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q   <= 4'b1111;
            display_q <= 7'b111_1111;
        end else begin
            digit_q   <= digit_d;
            display_q <= display_d;
        end
    end

    assign bus.msg_ack  = ack_q;
    assign bus.msg_busy = busy;
    assign bus.owner    = owner;
    assign bus.DIGIT    = digit_q;
    assign bus.DISPLAY  = display_q;
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Directed bench for seg_scan_arbiter: timed scan/blink/preempt sequences plus a glyph decode table.
module tb_seg_scan_arbiter;
    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] state_dbg;
    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    seg_scan_arbiter_if bus();

    seg_scan_arbiter #(.SCAN_DIV(4), .BLINK_DIV(64), .HOLD_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int n, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, n, act, exp);
        end
    endtask

    task automatic chk_cycle(input int n, input logic [3:0] e_dig, input logic [6:0] e_seg,
                             input logic e_own, input logic e_busy, input logic e_ack);
        chk("digit",   n, 16'(bus.DIGIT),    16'(e_dig));
        chk("display", n, 16'(bus.DISPLAY),  16'(e_seg));
        chk("owner",   n, 16'(bus.owner),    16'(e_own));
        chk("busy",    n, 16'(bus.msg_busy), 16'(e_busy));
        chk("ack",     n, 16'(bus.msg_ack),  16'(e_ack));
    endtask

    task automatic chk_reset(input int n);
        chk("rst_digit",   n, 16'(bus.DIGIT),    16'h000f);
        chk("rst_display", n, 16'(bus.DISPLAY),  16'h007f);
        chk("rst_owner",   n, 16'(bus.owner),    16'h0000);
        chk("rst_busy",    n, 16'(bus.msg_busy), 16'h0000);
        chk("rst_ack",     n, 16'(bus.msg_ack),  16'h0000);
        chk("rst_state",   n, 16'(state_dbg),    16'h0000);
    endtask

    // Cycle n counts from the first cycle after reset release; each digit is lit for 4 cycles.
    function automatic logic [3:0] scan_digit(input int n);
        logic [1:0] k;
        k = 2'((n / 4) % 4);
        return ~(4'b0001 << k);
    endfunction

    function automatic logic [6:0] seg_at(input logic [15:0] code, input int n);
        logic [1:0] k;
        logic [3:0] g;
        k = 2'((n / 4) % 4);
        g = code[{k, 2'b00} +: 4];
        return vecs[g].seg;
    endfunction

    initial begin
        vecs[0]  = '{4'd0,  7'b100_0000};
        vecs[1]  = '{4'd1,  7'b111_1001};
        vecs[2]  = '{4'd2,  7'b010_0100};
        vecs[3]  = '{4'd3,  7'b011_0000};
        vecs[4]  = '{4'd4,  7'b001_1001};
        vecs[5]  = '{4'd5,  7'b001_0010};
        vecs[6]  = '{4'd6,  7'b000_0010};
        vecs[7]  = '{4'd7,  7'b111_1000};
        vecs[8]  = '{4'd8,  7'b000_0000};
        vecs[9]  = '{4'd9,  7'b001_0000};
        vecs[10] = '{4'd10, 7'b101_1100};
        vecs[11] = '{4'd11, 7'b110_0011};
        vecs[12] = '{4'd12, 7'b000_1110};
        vecs[13] = '{4'd13, 7'b001_0010};
        vecs[14] = '{4'd14, 7'b111_1111};
        vecs[15] = '{4'd15, 7'b111_1111};

        rst = 1'b1;
        bus.disp_en  = 1'b1;
        bus.a_code   = 16'hA123;
        bus.a_blink  = 4'b0001;
        bus.msg_req  = 1'b0;
        bus.msg_code = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(-1);
        rst = 1'b0;
        step();

        // Scan order and digit-0 blink window (phase low for cycles 64..127).
        for (int n = 0; n <= 139; n++) begin
            logic blank;
            blank = ((n / 4) % 4 == 0) && (n >= 64) && (n <= 127);
            chk_cycle(n, scan_digit(n), blank ? 7'b111_1111 : seg_at(16'hA123, n), 1'b0, 1'b0, 1'b0);
            if (n == 139) bus.a_blink = 4'b0000;
            step();
        end

        // Mid-frame request, then an ignored request during SHOW.
        for (int n = 140; n <= 200; n++) begin
            logic b;
            b = (n >= 160) && (n <= 191);
            chk_cycle(n, scan_digit(n), seg_at(b ? 16'hCDEF : 16'hA123, n),
                      (n >= 159) && (n <= 190), (n >= 150) && (n <= 190), n == 150);
            bus.msg_req = (n == 149) || (n == 170);
            if (n == 149) bus.msg_code = 16'hCDEF;
            if (n == 170) bus.msg_code = 16'h1111;
            step();
        end

        // New request, reset lands in the second held frame.
        for (int n = 201; n <= 244; n++) begin
            chk_cycle(n, scan_digit(n), seg_at((n >= 224) ? 16'h5A5A : 16'hA123, n),
                      n >= 223, n >= 210, n == 210);
            bus.msg_req = (n == 209);
            if (n == 209) bus.msg_code = 16'h5A5A;
            if (n == 244) rst = 1'b1;
            step();
        end
        chk_reset(245);
        step();
        rst = 1'b0;
        step();

        // disp_en low for 20 cycles, then a continuously held request.
        for (int n = 0; n <= 130; n++) begin
            logic b;
            b = ((n >= 80) && (n <= 111)) || (n >= 128);
            chk_cycle(n, ((n >= 10) && (n <= 29)) ? 4'b1111 : scan_digit(n),
                      seg_at(b ? 16'h0987 : 16'hA123, n),
                      ((n >= 79) && (n <= 110)) || (n >= 127),
                      ((n >= 64) && (n <= 110)) || (n >= 112),
                      (n == 64) || (n == 112));
            bus.disp_en  = !((n >= 9) && (n <= 28));
            bus.msg_req  = (n >= 63);
            bus.msg_code = 16'h0987;
            step();
        end
        bus.msg_req = 1'b0;
        rst = 1'b1;
        step();
        chk_reset(0);
        rst = 1'b0;
        step();

        // Glyph decode table driven through client A on every digit.
        for (int i = 0; i < 16; i++) begin
            bus.a_code = {4{vecs[i].code}};
            step();
            chk("seg_tbl", i, 16'(bus.DISPLAY), 16'(vecs[i].seg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Time-multiplexed scan controller for the 4-digit 7-segment display, shared between two requesters. Client A is the live game value (direction/status glyph plus three BCD digits) and is always valid. Client B is a transient message that preempts A for a fixed number of whole frames. The block generates digit-scan and blink timing from the system clock with enable counters, so the display path needs no derived clocks.

## Interface
- SCAN_DIV, 100000: clock cycles each digit is lit (one scan tick); valid range ≥ 2.
- BLINK_DIV, 25000000: clock cycles per blink half-period; valid range ≥ 2.
- HOLD_FRAMES, 8: whole frames client B owns the display per request; valid range ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- disp_en  in  1  0 blanks all anodes; scanning and timers keep running.
- a_code  in  16  client A glyph codes {d3,d2,d1,d0}, 4 bits each; d0 is the rightmost digit.
- a_blink  in  4  per-digit blink mask for client A; bit i maps to digit i.
- msg_req  in  1  client B request, sampled each cycle.
- msg_code  in  16  client B glyph codes, captured with an accepted request.
- msg_ack  out  1  one-cycle pulse when a request is accepted.
- msg_busy  out  1  high while a B request is pending or showing.
- owner  out  1  0 = A drives the display, 1 = B drives it.
- DIGIT  out  4  anode enables, active-low, one-hot-zero.
- DISPLAY  out  7  segments {g..a}, active-low.

## Operation
- Glyph codes:
  - 0–9: decimal digits.
  - 10: UP (7'b101_1100).
  - 11: DOWN (7'b110_0011).
  - 12: F (7'b000_1110).
  - 13: S (7'b001_0010).
  - 14–15: blank (7'b111_1111).
  - Digit patterns are the standard active-low set: 0=7'b100_0000 … 9=7'b001_0000.
- Scan counter `sc` runs 0..SCAN_DIV-1. The scan tick is `sc==SCAN_DIV-1`.
- Digit index `idx` advances 0→1→2→3→0 on each scan tick.
- Frame boundary = the scan tick on which `idx` goes 3→0.
- Digit index to anode mapping: idx 0 → DIGIT 4'b1110, idx 1 → 4'b1101, idx 2 → 4'b1011, idx 3 → 4'b0111.
- Blink counter runs 0..BLINK_DIV-1 and toggles `phase` at its terminal count. `phase` is 1 (visible) after reset.
- Arbiter FSM:
  - IDLE: on msg_req, capture msg_code, pulse msg_ack, go to PEND.
  - PEND: at the next frame boundary, set owner=1, clear the frame count, go to SHOW.
  - SHOW: count frame boundaries. At the HOLD_FRAMES-th boundary, set owner=0 and go to IDLE.
- msg_busy = (state != IDLE).
- msg_req in PEND or SHOW is ignored: no ack, no recapture.
- Segment select:
  - The source is B's latched code when owner=1, otherwise a_code.
  - Blanking applies only to client A: if owner=0, phase=0 and a_blink[idx]=1, DISPLAY = 7'b111_1111.
  - If disp_en=0, DIGIT = 4'b1111. DISPLAY still follows the select logic.
- a_code and a_blink are sampled live, with no latching.

## Timing
- Reset values (registered, same edge):
  - DIGIT=4'b1111, DISPLAY=7'b111_1111.
  - msg_ack=0, msg_busy=0, owner=0.
  - state=IDLE, idx=0, sc=0, blink counter=0, phase=1.
- DIGIT and DISPLAY are registered from current idx/owner/phase/inputs. The first cycle after rst drops shows digit 0 of A (DIGIT=4'b1110).
- msg_ack and msg_busy rise one cycle after the msg_req sample edge.
- Ownership changes only at frame boundaries, so no frame is torn.
  - owner takes its new value in the cycle after the boundary tick.
  - The display outputs reflect the new owner one cycle later.
- Request pending/hold timing:
  - B waits at most one frame = 4·SCAN_DIV cycles before owning the display.
  - B is shown for exactly HOLD_FRAMES·4·SCAN_DIV cycles.
- Request on the same cycle as a frame boundary while IDLE: enters PEND and waits for the following boundary.
- msg_req held high continuously: re-accepted on the cycle after returning to IDLE, so A gets at least one partial frame before B can own again.
- rst mid-SHOW or mid-PEND: return to IDLE next edge, owner=0, and discard the captured code.
- Counter widths: $clog2 of each divisor. The frame counter is $clog2(HOLD_FRAMES+1) bits. No counter exceeds its terminal value.

## Test plan
- Use SCAN_DIV=4, BLINK_DIV=64, HOLD_FRAMES=2 for all scenarios.
- Reset and scan:
  - Stimulus: hold rst 3 cycles, a_code=16'hA123, disp_en=1.
  - Required: DIGIT cycles 1110,1101,1011,0111, each for 4 cycles.
  - Required: DISPLAY = 1→7'b111_1001, 2→7'b010_0100, 3→7'b011_0000, UP→7'b101_1100.
- Blink:
  - Stimulus: a_blink=4'b0001.
  - Required: digit 0 reads 7'b111_1111 during cycles 64–127 after reset; digits 1–3 are unaffected.
  - Required: digit 0 is visible again from cycle 128.
- Message preempt:
  - Stimulus: msg_req one cycle at mid-frame with msg_code=16'hCDEF.
  - Required: msg_ack pulses once; owner=1 from the next boundary for 32 cycles.
  - Required: displays F, S, blank, blank; owner=0 afterwards.
- Request while busy:
  - Stimulus: second msg_req during SHOW with 16'h1111.
  - Required: no msg_ack; shown code stays 16'hCDEF; msg_busy stays 1.
- Reset mid-SHOW:
  - Stimulus: assert rst in the second held frame.
  - Required: next edge gives owner=0, msg_busy=0, DIGIT=4'b1111; A is displayed after release.
- disp_en low:
  - Stimulus: drive disp_en=0 for 20 cycles.
  - Required: DIGIT=4'b1111 throughout.
  - Required: on return, idx continues from its advanced value and does not restart at 0.
